// File: rtl/fe_pipe_ctrl.sv
// rtl/fe_pipe_ctrl.sv - front-end IF1/IF2/ID pipeline sequencer with redirect arbitration
//
// Optional feature macro: FE_PERF_CNT_EN (adds perf_miss_cycles / perf_flush_cnt).
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   icache_stall            IF2 instruction not available (miss outstanding)
//   icache_resp_valid       miss refill returned to IF2 this cycle
//   be_stall                ID cannot accept a new instruction
//   bp_redir / bp_target    IF2 predicted-taken branch and its target
//   ex_redir / ex_target    EX mispredict and corrected target
//   wb_redir / wb_target    WB exception/ertn and its target
//   pc_wen                  PC register update enable
//   if1_if2_wen/_flush      if1/if2 stage register write enable / flush
//   if2_id_wen/_flush       if2/id stage register write enable / flush
//   redir_valid / redir_pc  PC must load redir_pc
//   drop_resp               IF2 must discard the current refill
//   perf_miss_cycles        (FE_PERF_CNT_EN) cycles spent in MISS or DRAIN
//   perf_flush_cnt          (FE_PERF_CNT_EN) if2/id flush cycles caused by wb/ex redirects

module fe_pipe_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_stall,
    input  logic        icache_resp_valid,
    input  logic        be_stall,
    input  logic        bp_redir,
    input  logic [31:0] bp_target,
    input  logic        ex_redir,
    input  logic [31:0] ex_target,
    input  logic        wb_redir,
    input  logic [31:0] wb_target,
    output logic        pc_wen,
    output logic        if1_if2_wen,
    output logic        if1_if2_flush,
    output logic        if2_id_wen,
    output logic        if2_id_flush,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic        drop_resp
`ifdef FE_PERF_CNT_EN
    ,
    output logic [31:0] perf_miss_cycles,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pend_pc;
    logic [31:0] pend_nxt;

    // Back-end redirects (wb beats ex) are treated as one source; bp is lowest.
    logic        hi_redir;
    logic [31:0] hi_target;
    logic        run_mode;
    logic        ic_eff;

    assign hi_redir  = wb_redir | ex_redir;
    assign hi_target = wb_redir ? wb_target : ex_target;

    always_comb begin
        pc_wen        = 1'b0;
        if1_if2_wen   = 1'b0;
        if1_if2_flush = 1'b0;
        if2_id_wen    = 1'b0;
        if2_id_flush  = 1'b0;
        redir_valid   = 1'b0;
        redir_pc      = pend_pc;
        drop_resp     = 1'b0;
        state_nxt     = state;
        pend_nxt      = pend_pc;
        run_mode      = 1'b0;
        ic_eff        = icache_stall;

        case (state)
            RUN: begin
                run_mode = 1'b1;
                ic_eff   = icache_stall;
            end
            MISS: begin
                if (icache_resp_valid) begin
                    // Refill arrives: behave as RUN with the miss resolved. A
                    // simultaneous wb/ex redirect is then applied immediately,
                    // since no further refill is outstanding to drain.
                    run_mode = 1'b1;
                    ic_eff   = 1'b0;
                end else if (hi_redir) begin
                    pend_nxt      = hi_target;
                    if1_if2_wen   = 1'b1;
                    if1_if2_flush = 1'b1;
                    if2_id_wen    = 1'b1;
                    if2_id_flush  = 1'b1;
                    state_nxt     = DRAIN;
                end else if (!be_stall) begin
                    if2_id_wen   = 1'b1;
                    if2_id_flush = 1'b1;
                end
            end
            DRAIN: begin
                if2_id_wen   = 1'b1;
                if2_id_flush = 1'b1;
                if (icache_resp_valid) begin
                    drop_resp     = 1'b1;
                    redir_valid   = 1'b1;
                    redir_pc      = hi_redir ? hi_target : pend_pc;
                    pc_wen        = 1'b1;
                    if1_if2_wen   = 1'b1;
                    if1_if2_flush = 1'b1;
                    state_nxt     = RUN;
                end else if (hi_redir) begin
                    pend_nxt = hi_target;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (run_mode) begin
            state_nxt = RUN;
            if (hi_redir) begin
                if1_if2_wen   = 1'b1;
                if1_if2_flush = 1'b1;
                if2_id_wen    = 1'b1;
                if2_id_flush  = 1'b1;
                if (!ic_eff) begin
                    redir_valid = 1'b1;
                    redir_pc    = hi_target;
                    pc_wen      = 1'b1;
                end else begin
                    // Miss in flight: park the target until the stale refill lands.
                    pend_nxt  = hi_target;
                    state_nxt = DRAIN;
                end
            end else if (bp_redir && !be_stall) begin
                // The predicted branch itself moves on to ID; only IF1 is squashed.
                redir_valid   = 1'b1;
                redir_pc      = bp_target;
                pc_wen        = 1'b1;
                if1_if2_wen   = 1'b1;
                if1_if2_flush = 1'b1;
                if2_id_wen    = 1'b1;
            end else if (be_stall) begin
                pc_wen = 1'b0;
            end else if (ic_eff) begin
                if2_id_wen   = 1'b1;
                if2_id_flush = 1'b1;
                state_nxt    = MISS;
            end else begin
                pc_wen      = 1'b1;
                if1_if2_wen = 1'b1;
                if2_id_wen  = 1'b1;
            end
        end

        if (!rst_n) begin
            pc_wen        = 1'b0;
            if1_if2_wen   = 1'b0;
            if1_if2_flush = 1'b0;
            if2_id_wen    = 1'b0;
            if2_id_flush  = 1'b0;
            redir_valid   = 1'b0;
            redir_pc      = RESET_PC;
            drop_resp     = 1'b0;
            state_nxt     = RUN;
            pend_nxt      = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        state   <= state_nxt;
        pend_pc <= pend_nxt;
    end

`ifdef FE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_miss_cycles <= 32'd0;
            perf_flush_cnt   <= 32'd0;
        end else begin
            if (state != RUN) begin
                perf_miss_cycles <= perf_miss_cycles + 32'd1;
            end
            if (if2_id_flush && hi_redir) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fe_pipe_ctrl.sv
// tb/tb_fe_pipe_ctrl.sv - directed scoreboard bench for fe_pipe_ctrl
module tb_fe_pipe_ctrl;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    // Expected control vector: {pc_wen, if1_if2_wen, if1_if2_flush, if2_id_wen, if2_id_flush, redir_valid, drop_resp}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_ALL   = 7'b1101000;
    localparam logic [6:0] C_BUB   = 7'b0001100;
    localparam logic [6:0] C_BP    = 7'b1111010;
    localparam logic [6:0] C_FRUN  = 7'b1111110;
    localparam logic [6:0] C_FLAT  = 7'b0111100;
    localparam logic [6:0] C_DIDLE = 7'b0001100;
    localparam logic [6:0] C_DRESP = 7'b1111111;

    logic        clk;
    logic        rst_n;
    logic        icache_stall;
    logic        icache_resp_valid;
    logic        be_stall;
    logic        bp_redir;
    logic [31:0] bp_target;
    logic        ex_redir;
    logic [31:0] ex_target;
    logic        wb_redir;
    logic [31:0] wb_target;
    logic        pc_wen;
    logic        if1_if2_wen;
    logic        if1_if2_flush;
    logic        if2_id_wen;
    logic        if2_id_flush;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        drop_resp;
`ifdef FE_PERF_CNT_EN
    logic [31:0] perf_miss_cycles;
    logic [31:0] perf_flush_cnt;
`endif

    fe_pipe_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .icache_stall      (icache_stall),
        .icache_resp_valid (icache_resp_valid),
        .be_stall          (be_stall),
        .bp_redir          (bp_redir),
        .bp_target         (bp_target),
        .ex_redir          (ex_redir),
        .ex_target         (ex_target),
        .wb_redir          (wb_redir),
        .wb_target         (wb_target),
        .pc_wen            (pc_wen),
        .if1_if2_wen       (if1_if2_wen),
        .if1_if2_flush     (if1_if2_flush),
        .if2_id_wen        (if2_id_wen),
        .if2_id_flush      (if2_id_flush),
        .redir_valid       (redir_valid),
        .redir_pc          (redir_pc),
        .drop_resp         (drop_resp)
`ifdef FE_PERF_CNT_EN
        ,
        .perf_miss_cycles  (perf_miss_cycles),
        .perf_flush_cnt    (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [6:0]  ctrl;
        logic        chk_pc;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned exp_miss = 0;
    int unsigned exp_flush = 0;

    // One cycle: drive inputs, push the expectation, compare mid-cycle, advance.
    // in_v = {icache_stall, icache_resp_valid, be_stall, bp_redir, ex_redir, wb_redir}
    // busy = the DUT is in MISS or DRAIN during this cycle (bench's own state model)
    task automatic step(input string tag, input logic rst, input logic [5:0] in_v,
                        input logic busy, input logic [6:0] exp_c,
                        input logic chk_pc, input logic [31:0] exp_pc);
        exp_t e;
        exp_t got;
        logic [6:0] act;
        rst_n             = rst;
        icache_stall      = in_v[5];
        icache_resp_valid = in_v[4];
        be_stall          = in_v[3];
        bp_redir          = in_v[2];
        ex_redir          = in_v[1];
        wb_redir          = in_v[0];
        e.tag = tag; e.ctrl = exp_c; e.chk_pc = chk_pc; e.pc = exp_pc;
        sb.push_back(e);
        if (!rst) begin
            exp_miss  = 0;
            exp_flush = 0;
        end else begin
            if (busy) exp_miss++;
            if (exp_c[2] && (in_v[1] || in_v[0])) exp_flush++;
        end
        @(negedge clk);
        got = sb.pop_front();
        act = {pc_wen, if1_if2_wen, if1_if2_flush, if2_id_wen, if2_id_flush, redir_valid, drop_resp};
        n_checks++;
        assert (act === got.ctrl) else begin
            n_fail++;
            $error("FAIL %s ctrl: observed %b expected %b", got.tag, act, got.ctrl);
        end
        if (got.chk_pc) begin
            n_checks++;
            assert (redir_pc === got.pc) else begin
                n_fail++;
                $error("FAIL %s redir_pc: observed %h expected %h", got.tag, redir_pc, got.pc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; icache_stall = 1'b0; icache_resp_valid = 1'b0; be_stall = 1'b0;
        bp_redir = 1'b0; ex_redir = 1'b0; wb_redir = 1'b0;
        bp_target = 32'h0; ex_target = 32'h0; wb_target = 32'h0;
        #1;

        step("reset0", 1'b0, 6'b000000, 1'b0, C_NONE, 1'b1, RST_PC);
        step("reset1", 1'b0, 6'b000000, 1'b0, C_NONE, 1'b1, RST_PC);
        step("run_first", 1'b1, 6'b000000, 1'b0, C_ALL, 1'b1, RST_PC);
        step("resp_in_run", 1'b1, 6'b010000, 1'b0, C_ALL, 1'b0, 32'h0);

        bp_target = 32'h1c00_0100;
        step("bp_redir", 1'b1, 6'b000100, 1'b0, C_BP, 1'b1, 32'h1c00_0100);

        step("miss_bub0", 1'b1, 6'b100000, 1'b0, C_BUB, 1'b0, 32'h0);
        for (int i = 1; i < 5; i++)
            step("miss_bub", 1'b1, 6'b100000, 1'b1, C_BUB, 1'b0, 32'h0);
        step("miss_resp", 1'b1, 6'b010000, 1'b1, C_ALL, 1'b0, 32'h0);
        step("after_miss", 1'b1, 6'b000000, 1'b0, C_ALL, 1'b0, 32'h0);

        ex_target = 32'h1c00_0180;
        step("ex_run", 1'b1, 6'b000010, 1'b0, C_FRUN, 1'b1, 32'h1c00_0180);
        wb_target = 32'h1c00_9000;
        step("wb_over_ex_run", 1'b1, 6'b000011, 1'b0, C_FRUN, 1'b1, 32'h1c00_9000);

        step("ex_miss_bub", 1'b1, 6'b100000, 1'b0, C_BUB, 1'b0, 32'h0);
        ex_target = 32'h1c00_0200;
        step("ex_in_miss", 1'b1, 6'b100010, 1'b1, C_FLAT, 1'b0, 32'h0);
        step("drain_idle0", 1'b1, 6'b100000, 1'b1, C_DIDLE, 1'b0, 32'h0);
        step("drain_idle1", 1'b1, 6'b100000, 1'b1, C_DIDLE, 1'b0, 32'h0);
        step("drain_resp", 1'b1, 6'b010000, 1'b1, C_DRESP, 1'b1, 32'h1c00_0200);
        step("after_drain", 1'b1, 6'b000000, 1'b0, C_ALL, 1'b0, 32'h0);

        step("wb_miss_bub", 1'b1, 6'b100000, 1'b0, C_BUB, 1'b0, 32'h0);
        ex_target = 32'h1c00_0300;
        step("ex300_in_miss", 1'b1, 6'b100010, 1'b1, C_FLAT, 1'b0, 32'h0);
        wb_target = 32'h1c00_8000;
        step("wb_ex_drain", 1'b1, 6'b100011, 1'b1, C_DIDLE, 1'b0, 32'h0);
        step("drain_resp_wb", 1'b1, 6'b010000, 1'b1, C_DRESP, 1'b1, 32'h1c00_8000);
        step("after_drain2", 1'b1, 6'b000000, 1'b0, C_ALL, 1'b0, 32'h0);

        bp_target = 32'h1c00_0400;
        step("be_bp_stall0", 1'b1, 6'b001100, 1'b0, C_NONE, 1'b0, 32'h0);
        step("be_bp_stall1", 1'b1, 6'b001100, 1'b0, C_NONE, 1'b0, 32'h0);
        step("be_bp_release", 1'b1, 6'b000100, 1'b0, C_BP, 1'b1, 32'h1c00_0400);

`ifdef FE_PERF_CNT_EN
        n_checks++;
        assert (perf_miss_cycles === exp_miss) else begin
            n_fail++;
            $error("FAIL perf_miss: observed %0d expected %0d", perf_miss_cycles, exp_miss);
        end
        n_checks++;
        assert (perf_flush_cnt === exp_flush) else begin
            n_fail++;
            $error("FAIL perf_flush: observed %0d expected %0d", perf_flush_cnt, exp_flush);
        end
`endif

        step("mb_bub", 1'b1, 6'b100000, 1'b0, C_BUB, 1'b0, 32'h0);
        step("miss_be_stall", 1'b1, 6'b101000, 1'b1, C_NONE, 1'b0, 32'h0);
        ex_target = 32'h1c00_0500;
        step("ex500_in_miss", 1'b1, 6'b100010, 1'b1, C_FLAT, 1'b0, 32'h0);
        step("reset_in_drain", 1'b0, 6'b110000, 1'b1, C_NONE, 1'b1, RST_PC);
        step("post_reset_run", 1'b1, 6'b000000, 1'b0, C_ALL, 1'b1, RST_PC);
        step("post_reset_resp", 1'b1, 6'b010000, 1'b0, C_ALL, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fe_pipe_ctrl.md
# fe_pipe_ctrl

Front-end pipeline sequencer for the IF1→IF2→ID path. It generates the write-enable and flush strobes for the PC register and the if1/if2 and if2/id stage registers. It arbitrates redirect requests from write-back, execute and the IF2 branch predictor. It handles redirects that arrive during an icache miss: it drains and discards the stale refill before steering the PC.

## Interface
Parameters:
- RESET_PC, 32'h1c00_0000, PC value presented on redir_pc while in reset and before any redirect.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- icache_stall  input  1  IF2 instruction not available this cycle (miss outstanding).
- icache_resp_valid  input  1  miss refill data returned to IF2 this cycle.
- be_stall  input  1  ID cannot accept a new instruction.
- bp_redir  input  1  IF2 predicted-taken branch.
- bp_target  input  32  predicted target.
- ex_redir  input  1  EX branch mispredict.
- ex_target  input  32  corrected target.
- wb_redir  input  1  exception or ertn from WB.
- wb_target  input  32  exception entry or era.
- pc_wen  output  1  PC register update enable.
- if1_if2_wen  output  1  if1/if2 register write enable.
- if1_if2_flush  output  1  if1/if2 register flush; only acts together with if1_if2_wen.
- if2_id_wen  output  1  if2/id register write enable.
- if2_id_flush  output  1  if2/id register flush; only acts together with if2_id_wen.
- redir_valid  output  1  the PC must load redir_pc.
- redir_pc  output  32  redirect target.
- drop_resp  output  1  IF2 must discard the current refill.

## Operation
- States: RUN, MISS, DRAIN. Registers: state, pend_pc[31:0].
- Source priority: wb > ex > bp. The selected source drives redir_pc.
- Whenever a flush output is 1, the matching wen output is also 1.

RUN:
- wb_redir or ex_redir, and icache_stall=0:
  - Outputs: redir_valid=1, pc_wen=1, both wens=1, both flushes=1.
  - This overrides be_stall. Stay in RUN.
- wb_redir or ex_redir, and icache_stall=1:
  - Latch the target into pend_pc.
  - Outputs: both flushes=1 (with their wens), redir_valid=0, pc_wen=0.
  - Next state: DRAIN.
- bp_redir only, be_stall=0:
  - Outputs: redir_valid=1, pc_wen=1, if1_if2_wen=1, if1_if2_flush=1, if2_id_wen=1, if2_id_flush=0.
  - The branch itself advances to ID.
- bp_redir only, be_stall=1: treated as a plain stall. bp_redir is re-sampled next cycle.
- be_stall=1, no wb/ex redirect: all wens=0.
- icache_stall=1, be_stall=0, no redirect:
  - Outputs: pc_wen=0, if1_if2_wen=0, if2_id_wen=1, if2_id_flush=1 (bubble into ID).
  - Next state: MISS.
- Otherwise: all wens=1, no flush.

MISS:
- pc_wen=0 and if1_if2_wen=0.
- If be_stall=0: if2_id_wen=1 and if2_id_flush=1 (bubbles). If be_stall=1: both 0.
- bp_redir is ignored.
- wb_redir or ex_redir: latch pend_pc, assert both flushes, next state DRAIN.
- icache_resp_valid with no redirect: next state RUN. That cycle's outputs follow the RUN rules with icache_stall treated as 0.

DRAIN:
- pc_wen=0, if1_if2_wen=0.
- if2_id_wen=1, if2_id_flush=1 every cycle.
- bp_redir is ignored.
- A new wb_redir or ex_redir overwrites pend_pc (wb wins if both).
- icache_resp_valid:
  - Outputs: drop_resp=1, redir_valid=1, redir_pc=pend_pc, pc_wen=1, if1_if2_wen=1, if1_if2_flush=1.
  - Next state: RUN.
- A wb/ex redirect in the same cycle as icache_resp_valid wins: its target is used directly, pend_pc is not needed.

## Timing
- All control outputs are combinational from state and inputs. The redirect reaches the PC register on the next clk edge.
- Reset (rst_n=0 at an edge):
  - state=RUN, pend_pc=RESET_PC.
  - While rst_n=0, outputs are forced to: all wens=0, all flushes=0, redir_valid=0, drop_resp=0, redir_pc=RESET_PC.
- Reset mid-miss or mid-drain returns to RUN. The icache is reset in the same cycle; no refill is dropped.
- Redirect latency:
  - RUN: 0 cycles to redir_valid.
  - DRAIN: redirect is emitted in the same cycle as icache_resp_valid.
- drop_resp is a 1-cycle pulse, only in DRAIN.
- icache_resp_valid arriving in RUN is ignored.

## Configuration
- FE_PERF_CNT_EN defined:
  - Adds output perf_miss_cycles[31:0]: increments each cycle in MISS or DRAIN.
  - Adds output perf_flush_cnt[31:0]: increments on each cycle with if2_id_flush=1 caused by a wb or ex redirect.
  - Both counters reset to 0 and wrap modulo 2^32.
- FE_PERF_CNT_EN undefined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- Reset, then release rst_n with no stalls:
  - During reset: all wens=0, redir_pc=32'h1c00_0000.
  - First RUN cycle: all wens=1, no flush.
- bp_redir=1, bp_target=32'h1c00_0100, be_stall=0 → redir_valid=1, redir_pc=32'h1c00_0100, if1_if2_flush=1, if2_id_flush=0.
- icache_stall=1 for 5 cycles, then icache_resp_valid=1:
  - 5 bubble cycles (if2_id_flush=1), pc_wen=0 throughout.
  - Return to RUN on the response cycle.
- ex_redir=1, ex_target=32'h1c00_0200 during a miss; 3 cycles later icache_resp_valid=1:
  - DRAIN is entered.
  - Response cycle: drop_resp=1, redir_valid=1, redir_pc=32'h1c00_0200.
- In DRAIN, ex_redir (32'h1c00_0300) and wb_redir (32'h1c00_8000) in the same cycle, then icache_resp_valid → redir_pc=32'h1c00_8000.
- be_stall=1 and bp_redir=1 for 2 cycles, then be_stall=0:
  - Stall cycles: all wens=0, redir_valid=0.
  - Release cycle: redirect applied.
  - With FE_PERF_CNT_EN: perf_flush_cnt unchanged.
